instr_sequencer: RTL and testbench

- Front-end controller for the 6-bit instruction input bus.
- Collects a variable number of 6-bit beats (1, 2, 3 or 4) into one complete instruction: opcode, src_a, src_b, dest and 8-bit imm.
- Presents the instruction to the execute stage with a valid/ready handshake and stalls the input while the execute stage is busy.
- Counts issued instructions for debug readout.

---
 rtl/instr_sequencer.sv | 99 +++++++++
 tb/tb_instr_sequencer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
// Instruction front end: assembles 1-4 six-bit beats into one instruction and
// holds it on a valid/ready interface to execute, counting completed issues.
module instr_sequencer #(
    parameter logic [7:0] REG_MASK = 8'b0111_1110,
    parameter logic [7:0] IMM_MASK = 8'b0110_0000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] in,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       flush,
    output logic       op_valid,
    input  logic       op_ready,
    output logic [2:0] opcode,
    output logic [2:0] src_a,
    output logic [2:0] src_b,
    output logic [2:0] dest,
    output logic [7:0] imm,
    output logic [7:0] instr_count
);

    typedef enum logic [2:0] {OP, REG, IMM_LO, IMM_HI, ISSUE} state_t;

    state_t     state;
    logic [2:0] in_op;

    assign in_ready = (state != ISSUE);
    assign in_op    = in[5:3];

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= OP;
            op_valid    <= 1'b0;
            opcode      <= '0;
            src_a       <= '0;
            src_b       <= '0;
            dest        <= '0;
            imm         <= '0;
            instr_count <= '0;
        end else begin
            // A handshake on the flush edge is already consumed downstream.
            if (op_valid && op_ready)
                instr_count <= instr_count + 8'd1;

            if (flush) begin
                state    <= OP;
                op_valid <= 1'b0;
            end else begin
                case (state)
                    OP: if (in_valid) begin
                        opcode <= in_op;
                        src_a  <= in[2:0];
                        src_b  <= '0;
                        dest   <= '0;
                        imm    <= '0;
                        if (REG_MASK[in_op])
                            state <= REG;
                        else if (IMM_MASK[in_op])
                            state <= IMM_LO;
                        else begin
                            state    <= ISSUE;
                            op_valid <= 1'b1;
                        end
                    end
                    // Class decided from the opcode latched at OP time.
                    REG: if (in_valid) begin
                        src_b <= in[5:3];
                        dest  <= in[2:0];
                        if (IMM_MASK[opcode])
                            state <= IMM_LO;
                        else begin
                            state    <= ISSUE;
                            op_valid <= 1'b1;
                        end
                    end
                    IMM_LO: if (in_valid) begin
                        imm[5:0] <= in;
                        state    <= IMM_HI;
                    end
                    IMM_HI: if (in_valid) begin
                        imm[7:6] <= in[1:0];
                        state    <= ISSUE;
                        op_valid <= 1'b1;
                    end
                    ISSUE: if (op_ready) begin
                        state    <= OP;
                        op_valid <= 1'b0;
                    end
                    default: begin
                        state    <= OP;
                        op_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: table of instructions plus hand-built flush,
// wrap and reset sequences; issued fields are checked through a scoreboard.
module tb_instr_sequencer;

    logic       clk = 1'b0;
    logic       rst, flush, in_valid, op_ready;
    logic [5:0] in;
    logic       in_ready, op_valid;
    logic [2:0] opcode, src_a, src_b, dest;
    logic [7:0] imm, instr_count;

    instr_sequencer dut (
        .clk(clk), .rst(rst), .in(in), .in_valid(in_valid), .in_ready(in_ready),
        .flush(flush), .op_valid(op_valid), .op_ready(op_ready),
        .opcode(opcode), .src_a(src_a), .src_b(src_b), .dest(dest), .imm(imm),
        .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] op, sa, sb, d;
        logic [7:0] imm;
    } fld_t;

    typedef struct {
        int         n;
        logic [5:0] b0, b1, b2, b3;
        int         gap;
        int         stall;
        fld_t       exp;
    } vec_t;

    fld_t       sbq[$];
    int         total = 0;
    int         bad   = 0;
    logic [7:0] exp_count;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Inputs are driven just after the rising edge; the monitor samples at the
    // falling edge, so a handshake seen there is the one the next edge takes.
    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    always @(negedge clk) begin
        if (!rst && op_valid && op_ready) begin
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_empty: got handshake opcode=%0d expected none", opcode);
            end else begin
                fld_t e;
                e = sbq.pop_front();
                chk("sb_opcode", opcode, e.op);
                chk("sb_src_a", src_a, e.sa);
                chk("sb_src_b", src_b, e.sb);
                chk("sb_dest", dest, e.d);
                chk("sb_imm", imm, e.imm);
            end
        end
    end

    task automatic do_reset;
        rst = 1'b1;
        tick;
        tick;
        rst = 1'b0;
        sbq.delete();
        exp_count = 8'd0;
    endtask

    task automatic run_vec(input vec_t v);
        logic [5:0] bt[4];
        bt = '{v.b0, v.b1, v.b2, v.b3};
        sbq.push_back(v.exp);
        for (int i = 0; i < v.n; i++) begin
            chk("in_ready_beat", in_ready, 1);
            chk("op_valid_early", op_valid, 0);
            in = bt[i];
            in_valid = 1'b1;
            tick;
            in_valid = 1'b0;
            if (i == 0 && v.n > 1)
                for (int g = 0; g < v.gap; g++) begin
                    chk("gap_op_valid", op_valid, 0);
                    chk("gap_opcode", opcode, v.exp.op);
                    tick;
                end
        end
        chk("op_valid_after_last", op_valid, 1);
        chk("in_ready_issue", in_ready, 0);
        for (int s = 0; s < v.stall; s++) begin
            in = 6'h3F;
            in_valid = 1'b1;
            tick;
            chk("stall_op_valid", op_valid, 1);
            chk("stall_in_ready", in_ready, 0);
            chk("stall_opcode", opcode, v.exp.op);
            chk("stall_dest", dest, v.exp.d);
            chk("stall_imm", imm, v.exp.imm);
            chk("stall_count", instr_count, exp_count);
        end
        in_valid = 1'b0;
        op_ready = 1'b1;
        tick;
        op_ready = 1'b0;
        exp_count = exp_count + 8'd1;
        chk("op_valid_drop", op_valid, 0);
        chk("in_ready_back", in_ready, 1);
        chk("instr_count", instr_count, exp_count);
    endtask

    vec_t tbl[6];
    vec_t nop, op7;

    initial begin
        //            n  b0          b1          b2         b3        gap stall {op sa sb d imm}
        tbl[0] = '{1, 6'b000_101, 6'b0,      6'b0,      6'b0,      0, 0, '{3'd0, 3'd5, 3'd0, 3'd0, 8'h00}};
        tbl[1] = '{2, 6'b001_010, 6'b011_100, 6'b0,     6'b0,      3, 0, '{3'd1, 3'd2, 3'd3, 3'd4, 8'h00}};
        tbl[2] = '{4, 6'b110_001, 6'b000_111, 6'b101010, 6'b111110, 0, 0, '{3'd6, 3'd1, 3'd0, 3'd7, 8'hAA}};
        tbl[3] = '{4, 6'b101_010, 6'b110_011, 6'b001111, 6'b000001, 1, 5, '{3'd5, 3'd2, 3'd6, 3'd3, 8'h4F}};
        tbl[4] = '{1, 6'b111_011, 6'b0,      6'b0,      6'b0,      0, 2, '{3'd7, 3'd3, 3'd0, 3'd0, 8'h00}};
        tbl[5] = '{2, 6'b100_110, 6'b101_001, 6'b0,     6'b0,      0, 1, '{3'd4, 3'd6, 3'd5, 3'd1, 8'h00}};
        nop = tbl[0];
        op7 = tbl[4];
        op7.stall = 0;

        flush = 1'b0; in_valid = 1'b1; in = 6'b001_010; op_ready = 1'b1;
        do_reset;
        in_valid = 1'b0; op_ready = 1'b0;
        chk("rst_op_valid", op_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_opcode", opcode, 0);
        chk("rst_imm", imm, 0);
        chk("rst_count", instr_count, 0);

        foreach (tbl[i]) run_vec(tbl[i]);

        // Flush after two of four ADDI beats: nothing issues, then a 1-beat op.
        in = 6'b110_001; in_valid = 1'b1; tick;
        in = 6'b000_111; tick;
        in_valid = 1'b0; flush = 1'b1; tick;
        flush = 1'b0;
        chk("flush_op_valid", op_valid, 0);
        chk("flush_in_ready", in_ready, 1);
        tick;
        chk("flush_op_valid2", op_valid, 0);
        run_vec(op7);

        // A beat offered alongside flush is dropped, so the next beat is an OP.
        in = 6'b001_010; in_valid = 1'b1; flush = 1'b1; tick;
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_beat_op_valid", op_valid, 0);
        run_vec(op7);

        // Flush and handshake in the same cycle still count the issue.
        sbq.push_back(nop.exp);
        in = nop.b0; in_valid = 1'b1; tick;
        in_valid = 1'b0;
        chk("fh_op_valid", op_valid, 1);
        op_ready = 1'b1; flush = 1'b1; tick;
        op_ready = 1'b0; flush = 1'b0;
        exp_count = exp_count + 8'd1;
        chk("fh_count", instr_count, exp_count);
        chk("fh_op_valid_drop", op_valid, 0);
        chk("fh_in_ready", in_ready, 1);

        // Counter wrap after 256 handshakes from reset.
        do_reset;
        for (int k = 0; k < 255; k++) run_vec(nop);
        chk("count_255", instr_count, 255);
        run_vec(nop);
        chk("count_wrap", instr_count, 0);

        // Reset mid-ADD clears everything and leaves the sequencer in OP.
        run_vec(op7);
        in = 6'b001_010; in_valid = 1'b1; tick;
        in_valid = 1'b0;
        do_reset;
        chk("mid_rst_op_valid", op_valid, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_opcode", opcode, 0);
        chk("mid_rst_src_a", src_a, 0);
        chk("mid_rst_src_b", src_b, 0);
        chk("mid_rst_dest", dest, 0);
        chk("mid_rst_imm", imm, 0);
        chk("mid_rst_count", instr_count, 0);
        run_vec(op7);

        chk("sb_drained", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
